// File: rtl/gr8_dram_pkg.sv
// Shared types and address-split constants for the GR8 DRAM scheduler.
package gr8_dram_pkg;

    localparam int ADDR_W   = 23;
    localparam int RA_W     = 11;
    localparam int BANK_BIT = 22;
    localparam int ROW_HI   = 21;
    localparam int ROW_LO   = 11;
    localparam int COL_HI   = 10;
    localparam int COL_LO   = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ROW     = 3'd1,
        COL     = 3'd2,
        PRE     = 3'd3,
        REF_CAS = 3'd4,
        REF_RAS = 3'd5
    } sched_state_t;

    typedef enum logic [1:0] {
        OWN_SLOT = 2'd0,
        OWN_BG   = 2'd1,
        OWN_REF  = 2'd2
    } sched_owner_t;

    function automatic logic [RA_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return a[ROW_HI:ROW_LO];
    endfunction

    function automatic logic [RA_W-1:0] col_of(input logic [ADDR_W-1:0] a);
        return a[COL_HI:COL_LO];
    endfunction

    function automatic logic bank_of(input logic [ADDR_W-1:0] a);
        return a[BANK_BIT];
    endfunction

endpackage

// File: rtl/gr8_dram_sched_if.sv
// Level-request / one-cycle-ack port used by the slot and background requesters.
interface gr8_dram_sched_if;
    import gr8_dram_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              ack;

    modport master (output req, output we, output addr, input ack);
    modport slave  (input req, input we, input addr, output ack);

endinterface

// File: rtl/gr8_refresh_timer.sv
// Refresh interval counter with a saturating count of owed CBR refreshes.
module gr8_refresh_timer #(
    parameter int REF_INTERVAL = 112,
    parameter int REF_MAX      = 3,
    parameter int PEND_W       = 2
) (
    input  logic              C7M,
    input  logic              nRES,
    input  logic              i_consume,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_ref_ovr
);

    localparam int TMR_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    logic [TMR_W-1:0]  r_timer;
    logic [PEND_W-1:0] r_pending;
    logic              r_ovr;
    logic              w_tick;
    logic              w_full;

    assign w_tick    = (r_timer == TMR_W'(REF_INTERVAL - 1));
    assign w_full    = (r_pending == PEND_W'(REF_MAX));
    assign o_pending = r_pending;
    assign o_ref_ovr = r_ovr;

    // Free-running interval timer; tick adds a refresh, a started CBR removes one.
    always_ff @(posedge C7M) begin
        if (!nRES) begin
            r_timer   <= '0;
            r_pending <= '0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_tick) r_timer <= '0;
            else        r_timer <= r_timer + 1'b1;

            if (w_tick && !i_consume) begin
                if (!w_full) r_pending <= r_pending + 1'b1;
            end else if (!w_tick && i_consume && (r_pending != '0)) begin
                r_pending <= r_pending - 1'b1;
            end

            if (w_tick && w_full) r_ovr <= 1'b1;
        end
    end

endmodule

// File: rtl/gr8_dram_sched.sv
// DRAM sequencer/arbiter: slot accesses, CBR refresh and background engine
// share one DRAM. All DRAM strobes are registered from the next-state decode.
//
//  state   | meaning
//  IDLE    | nothing granted, strobes high
//  ROW     | row address driven, nRAS low
//  COL     | column address, nRAS + selected nCAS low, ack on last cycle
//  PRE     | precharge, strobes high; last cycle re-arbitrates
//  REF_CAS | CBR step 1: both nCAS low, nRAS high
//  REF_RAS | CBR step 2: nRAS low with both nCAS low
module gr8_dram_sched
    import gr8_dram_pkg::*;
#(
    parameter int REF_INTERVAL = 112,
    parameter int CAS_CYC      = 2,
    parameter int RAS_CYC      = 2,
    parameter int PRE_CYC      = 2,
    parameter int REF_MAX      = 3
) (
    input  logic            C7M,
    input  logic            nRES,
    gr8_dram_sched_if.slave slot,
    gr8_dram_sched_if.slave bg,
    output logic [RA_W-1:0] RA,
    output logic            nRAS,
    output logic            nCAS0,
    output logic            nCAS1,
    output logic            nRWE,
    output logic            busy,
    output logic            ref_ovr
);

    localparam int PEND_W  = $clog2(REF_MAX + 1);
    localparam int CNT_MAX = (CAS_CYC > RAS_CYC) ? ((CAS_CYC > PRE_CYC) ? CAS_CYC : PRE_CYC)
                                                 : ((RAS_CYC > PRE_CYC) ? RAS_CYC : PRE_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    sched_state_t      r_state, w_state_nxt;
    sched_owner_t      r_owner, w_owner_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              w_arb;
    logic              w_consume;
    logic [PEND_W-1:0] w_pending;

    logic [RA_W-1:0]   r_ra, w_ra;
    logic              r_nras, w_nras;
    logic              r_ncas0, w_ncas0;
    logic              r_ncas1, w_ncas1;
    logic              r_nrwe, w_nrwe;
    logic              r_slot_ack, w_slot_ack;
    logic              r_bg_ack, w_bg_ack;
    logic              r_busy;

    gr8_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL),
        .REF_MAX     (REF_MAX),
        .PEND_W      (PEND_W)
    ) u_timer (
        .C7M      (C7M),
        .nRES     (nRES),
        .i_consume(w_consume),
        .o_pending(w_pending),
        .o_ref_ovr(ref_ovr)
    );

    // Next-state: sequence timing plus priority arbitration at IDLE / end of PRE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_arb       = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            IDLE: w_arb = 1'b1;
            ROW: begin
                w_state_nxt = COL;
                w_cnt_nxt   = CNT_W'(CAS_CYC - 1);
            end
            COL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = PRE;
                    w_cnt_nxt   = CNT_W'(PRE_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            REF_CAS: begin
                w_state_nxt = REF_RAS;
                w_cnt_nxt   = CNT_W'(RAS_CYC - 1);
                w_consume   = 1'b1;
            end
            REF_RAS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = PRE;
                    w_cnt_nxt   = CNT_W'(PRE_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            PRE: begin
                if (r_cnt == '0) w_arb = 1'b1;
                else             w_cnt_nxt = r_cnt - 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_arb) begin
            if (w_pending == PEND_W'(REF_MAX)) begin
                w_state_nxt = REF_CAS;
                w_owner_nxt = OWN_REF;
            end else if (slot.req) begin
                w_state_nxt = ROW;
                w_owner_nxt = OWN_SLOT;
                w_we_nxt    = slot.we;
                w_addr_nxt  = slot.addr;
            end else if (w_pending != '0) begin
                w_state_nxt = REF_CAS;
                w_owner_nxt = OWN_REF;
            end else if (bg.req) begin
                w_state_nxt = ROW;
                w_owner_nxt = OWN_BG;
                w_we_nxt    = bg.we;
                w_addr_nxt  = bg.addr;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    // Strobe/address decode of the state being entered, so pins change with the state.
    always_comb begin
        w_ra       = r_ra;
        w_nras     = 1'b1;
        w_ncas0    = 1'b1;
        w_ncas1    = 1'b1;
        w_nrwe     = 1'b1;
        w_slot_ack = 1'b0;
        w_bg_ack   = 1'b0;
        case (w_state_nxt)
            ROW: begin
                w_ra   = row_of(w_addr_nxt);
                w_nras = 1'b0;
            end
            COL: begin
                w_ra   = col_of(w_addr_nxt);
                w_nras = 1'b0;
                if (bank_of(w_addr_nxt)) w_ncas1 = 1'b0;
                else                     w_ncas0 = 1'b0;
                w_nrwe = ~w_we_nxt;
                if (w_cnt_nxt == '0) begin
                    if (w_owner_nxt == OWN_SLOT) w_slot_ack = 1'b1;
                    else                         w_bg_ack   = 1'b1;
                end
            end
            REF_CAS: begin
                w_ncas0 = 1'b0;
                w_ncas1 = 1'b0;
            end
            REF_RAS: begin
                w_nras  = 1'b0;
                w_ncas0 = 1'b0;
                w_ncas1 = 1'b0;
            end
            default: ;
        endcase
    end

    // State, latched grant and registered DRAM pins; reset aborts any operation.
    always_ff @(posedge C7M) begin
        if (!nRES) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_owner    <= OWN_SLOT;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_ra       <= '0;
            r_nras     <= 1'b1;
            r_ncas0    <= 1'b1;
            r_ncas1    <= 1'b1;
            r_nrwe     <= 1'b1;
            r_slot_ack <= 1'b0;
            r_bg_ack   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_owner    <= w_owner_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_ra       <= w_ra;
            r_nras     <= w_nras;
            r_ncas0    <= w_ncas0;
            r_ncas1    <= w_ncas1;
            r_nrwe     <= w_nrwe;
            r_slot_ack <= w_slot_ack;
            r_bg_ack   <= w_bg_ack;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign RA       = r_ra;
    assign nRAS     = r_nras;
    assign nCAS0    = r_ncas0;
    assign nCAS1    = r_ncas1;
    assign nRWE     = r_nrwe;
    assign busy     = r_busy;
    assign slot.ack = r_slot_ack;
    assign bg.ack   = r_bg_ack;

endmodule

// File: tb/tb_gr8_dram_sched.sv
// Directed bench for gr8_dram_sched; a second instance with a short refresh
// interval exercises refresh overflow.
module tb_gr8_dram_sched;
    import gr8_dram_pkg::*;

    logic C7M = 1'b0;
    logic nRES = 1'b0;
    int   checks = 0;
    int   failures = 0;

    gr8_dram_sched_if slot_if();
    gr8_dram_sched_if bg_if();
    gr8_dram_sched_if slot2_if();
    gr8_dram_sched_if bg2_if();

    logic [10:0] RA, RA2;
    logic nRAS, nCAS0, nCAS1, nRWE, busy, ref_ovr;
    logic nRAS2, nCAS02, nCAS12, nRWE2, busy2, ref_ovr2;

    always #5 C7M = ~C7M;

    gr8_dram_sched #(.REF_INTERVAL(112), .CAS_CYC(2), .RAS_CYC(2), .PRE_CYC(2), .REF_MAX(3)) dut (
        .C7M(C7M), .nRES(nRES), .slot(slot_if), .bg(bg_if), .RA(RA), .nRAS(nRAS),
        .nCAS0(nCAS0), .nCAS1(nCAS1), .nRWE(nRWE), .busy(busy), .ref_ovr(ref_ovr));

    gr8_dram_sched #(.REF_INTERVAL(4), .CAS_CYC(2), .RAS_CYC(2), .PRE_CYC(2), .REF_MAX(3)) dut2 (
        .C7M(C7M), .nRES(nRES), .slot(slot2_if), .bg(bg2_if), .RA(RA2), .nRAS(nRAS2),
        .nCAS0(nCAS02), .nCAS1(nCAS12), .nRWE(nRWE2), .busy(busy2), .ref_ovr(ref_ovr2));

    task automatic step();
        @(posedge C7M);
        #1;
    endtask

    task automatic do_reset();
        slot_if.req = 1'b0; slot_if.we = 1'b0; slot_if.addr = '0;
        bg_if.req = 1'b0;   bg_if.we = 1'b0;   bg_if.addr = '0;
        nRES = 1'b0;
        step();
        step();
        nRES = 1'b1;
    endtask

    task automatic test_reset();
        slot2_if.req = 1'b0; slot2_if.we = 1'b0; slot2_if.addr = '0;
        bg2_if.req = 1'b0;   bg2_if.we = 1'b0;   bg2_if.addr = '0;
        nRES = 1'b0;
        slot_if.req = 1'b1; slot_if.we = 1'b1; slot_if.addr = 23'h412345;
        bg_if.req = 1'b1;   bg_if.we = 1'b1;   bg_if.addr = 23'h000000;
        step();
        step();
        checks++; if (RA !== 11'h000) begin failures++; $display("FAIL reset_ra got=%h exp=000", RA); end
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE} !== 4'b1111) begin failures++; $display("FAIL reset_strobes got=%b exp=1111", {nRAS, nCAS0, nCAS1, nRWE}); end
        checks++; if ({busy, ref_ovr, slot_if.ack, bg_if.ack} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, ref_ovr, slot_if.ack, bg_if.ack}); end
        checks++; if (dut.w_pending !== 2'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", dut.w_pending); end
    endtask

    task automatic test_slot_read();
        logic [22:0] a;
        a = 23'h412345;
        do_reset();
        slot_if.req = 1'b1; slot_if.we = 1'b0; slot_if.addr = a;
        step();
        checks++; if (RA !== a[21:11]) begin failures++; $display("FAIL rd_row_ra got=%h exp=%h", RA, a[21:11]); end
        checks++; if ({nRAS, nCAS0, nCAS1, busy} !== 4'b0111) begin failures++; $display("FAIL rd_row_strobes got=%b exp=0111", {nRAS, nCAS0, nCAS1, busy}); end
        step();
        checks++; if (RA !== a[10:0]) begin failures++; $display("FAIL rd_col_ra got=%h exp=%h", RA, a[10:0]); end
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE, slot_if.ack} !== 5'b01010) begin failures++; $display("FAIL rd_col1 got=%b exp=01010", {nRAS, nCAS0, nCAS1, nRWE, slot_if.ack}); end
        step();
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE, slot_if.ack} !== 5'b01011) begin failures++; $display("FAIL rd_col2_ack got=%b exp=01011", {nRAS, nCAS0, nCAS1, nRWE, slot_if.ack}); end
        slot_if.req = 1'b0;
        step();
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE, slot_if.ack} !== 5'b11110) begin failures++; $display("FAIL rd_pre got=%b exp=11110", {nRAS, nCAS0, nCAS1, nRWE, slot_if.ack}); end
        checks++; if (RA !== a[10:0]) begin failures++; $display("FAIL rd_pre_ra_hold got=%h exp=%h", RA, a[10:0]); end
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd_pre2_busy got=%b exp=1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_arbitrate();
        logic [22:0] a, b;
        a = 23'h412345;
        b = 23'h3FF800;
        do_reset();
        slot_if.req = 1'b1; slot_if.we = 1'b0; slot_if.addr = a;
        bg_if.req = 1'b1;   bg_if.we = 1'b0;   bg_if.addr = b;
        step();
        checks++; if (RA !== a[21:11]) begin failures++; $display("FAIL arb_slot_first got=%h exp=%h", RA, a[21:11]); end
        step();
        step();
        checks++; if ({slot_if.ack, bg_if.ack} !== 2'b10) begin failures++; $display("FAIL arb_slot_ack got=%b exp=10", {slot_if.ack, bg_if.ack}); end
        slot_if.req = 1'b0;
        step();
        step();
        checks++; if ({nRAS, bg_if.ack} !== 2'b10) begin failures++; $display("FAIL arb_pre_gap got=%b exp=10", {nRAS, bg_if.ack}); end
        step();
        checks++; if ({nRAS, RA} !== {1'b0, b[21:11]}) begin failures++; $display("FAIL arb_bg_row_n5 got=%b/%h exp=0/%h", nRAS, RA, b[21:11]); end
        step();
        checks++; if ({nCAS0, nCAS1, RA} !== {2'b01, b[10:0]}) begin failures++; $display("FAIL arb_bg_col got=%b%b/%h exp=01/%h", nCAS0, nCAS1, RA, b[10:0]); end
        step();
        checks++; if ({slot_if.ack, bg_if.ack} !== 2'b01) begin failures++; $display("FAIL arb_bg_ack got=%b exp=01", {slot_if.ack, bg_if.ack}); end
        bg_if.req = 1'b0;
    endtask

    task automatic test_bg_write();
        do_reset();
        bg_if.req = 1'b1; bg_if.we = 1'b1; bg_if.addr = 23'h000000;
        step();
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE} !== 4'b0111) begin failures++; $display("FAIL bgw_row got=%b exp=0111", {nRAS, nCAS0, nCAS1, nRWE}); end
        step();
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE, bg_if.ack} !== 5'b00100) begin failures++; $display("FAIL bgw_col1 got=%b exp=00100", {nRAS, nCAS0, nCAS1, nRWE, bg_if.ack}); end
        step();
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE, bg_if.ack} !== 5'b00101) begin failures++; $display("FAIL bgw_col2 got=%b exp=00101", {nRAS, nCAS0, nCAS1, nRWE, bg_if.ack}); end
        bg_if.req = 1'b0;
        step();
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE, bg_if.ack} !== 5'b11110) begin failures++; $display("FAIL bgw_pre got=%b exp=11110", {nRAS, nCAS0, nCAS1, nRWE, bg_if.ack}); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        slot_if.req = 1'b1; slot_if.we = 1'b1; slot_if.addr = 23'h012345;
        step();
        step();
        checks++; if ({nCAS0, nRWE} !== 2'b00) begin failures++; $display("FAIL mid_col_write got=%b exp=00", {nCAS0, nRWE}); end
        nRES = 1'b0;
        step();
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE, busy, slot_if.ack} !== 6'b111100) begin failures++; $display("FAIL mid_reset_abort got=%b exp=111100", {nRAS, nCAS0, nCAS1, nRWE, busy, slot_if.ack}); end
        slot_if.req = 1'b0;
        nRES = 1'b1;
        step();
        checks++; if ({busy, slot_if.ack} !== 2'b00) begin failures++; $display("FAIL mid_after_release got=%b exp=00", {busy, slot_if.ack}); end
    endtask

    task automatic test_back_to_back();
        logic [22:0] a1, a2;
        a1 = 23'h412345;
        a2 = 23'h1ABCDE;
        do_reset();
        slot_if.req = 1'b1; slot_if.we = 1'b0; slot_if.addr = a1;
        step();
        step();
        step();
        checks++; if (slot_if.ack !== 1'b1) begin failures++; $display("FAIL b2b_ack1 got=%b exp=1", slot_if.ack); end
        slot_if.we = 1'b1; slot_if.addr = a2;
        step();
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_pre got=%b exp=1", busy); end
        step();
        checks++; if ({nRAS, RA} !== {1'b0, a2[21:11]}) begin failures++; $display("FAIL b2b_row2 got=%b/%h exp=0/%h", nRAS, RA, a2[21:11]); end
        step();
        checks++; if ({nCAS0, nCAS1, nRWE, RA} !== {3'b010, a2[10:0]}) begin failures++; $display("FAIL b2b_col2 got=%b/%h exp=010/%h", {nCAS0, nCAS1, nRWE}, RA, a2[10:0]); end
        step();
        checks++; if (slot_if.ack !== 1'b1) begin failures++; $display("FAIL b2b_ack2 got=%b exp=1", slot_if.ack); end
        slot_if.req = 1'b0;
    endtask

    task automatic test_ref_vs_bg();
        logic [22:0] b;
        b = 23'h3FF800;
        do_reset();
        repeat (112) step();
        checks++; if ({dut.w_pending, busy} !== 3'b010) begin failures++; $display("FAIL rvb_tick got=%0d/%b exp=1/0", dut.w_pending, busy); end
        bg_if.req = 1'b1; bg_if.we = 1'b0; bg_if.addr = b;
        step();
        checks++; if ({nRAS, nCAS0, nCAS1, nRWE} !== 4'b1001) begin failures++; $display("FAIL rvb_ref_cas got=%b exp=1001", {nRAS, nCAS0, nCAS1, nRWE}); end
        step();
        checks++; if ({nRAS, nCAS0, nCAS1} !== 3'b000) begin failures++; $display("FAIL rvb_ref_ras got=%b exp=000", {nRAS, nCAS0, nCAS1}); end
        checks++; if (dut.w_pending !== 2'd0) begin failures++; $display("FAIL rvb_pending_dec got=%0d exp=0", dut.w_pending); end
        repeat (4) step();
        checks++; if ({nRAS, nCAS0, nCAS1, RA} !== {3'b011, b[21:11]}) begin failures++; $display("FAIL rvb_bg_row got=%b/%h exp=011/%h", {nRAS, nCAS0, nCAS1}, RA, b[21:11]); end
        step();
        step();
        checks++; if (bg_if.ack !== 1'b1) begin failures++; $display("FAIL rvb_bg_ack got=%b exp=1", bg_if.ack); end
        bg_if.req = 1'b0;
    endtask

    task automatic test_refresh_hold();
        int acks, refs, first_ref, maxp, ovr_seen;
        acks = 0; refs = 0; first_ref = 0; maxp = 0; ovr_seen = 0;
        do_reset();
        slot_if.req = 1'b1; slot_if.we = 1'b0; slot_if.addr = 23'h412345;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (slot_if.ack === 1'b1) acks++;
            if (nRAS === 1'b1 && nCAS0 === 1'b0 && nCAS1 === 1'b0) begin
                refs++;
                if (first_ref == 0) first_ref = k;
            end
            if (int'(dut.w_pending) > maxp) maxp = int'(dut.w_pending);
            if (ref_ovr !== 1'b0) ovr_seen = 1;
        end
        slot_if.req = 1'b0;
        checks++; if (maxp !== 3) begin failures++; $display("FAIL hold_pending_max got=%0d exp=3", maxp); end
        checks++; if (refs !== 1) begin failures++; $display("FAIL hold_ref_count got=%0d exp=1", refs); end
        checks++; if (first_ref !== 341) begin failures++; $display("FAIL hold_ref_edge got=%0d exp=341", first_ref); end
        checks++; if (acks !== 79) begin failures++; $display("FAIL hold_ack_count got=%0d exp=79", acks); end
        checks++; if (ovr_seen !== 0) begin failures++; $display("FAIL hold_ref_ovr got=%0d exp=0", ovr_seen); end
        checks++; if (dut.w_pending !== 2'd2) begin failures++; $display("FAIL hold_pending_end got=%0d exp=2", dut.w_pending); end
    endtask

    task automatic test_ref_ovr();
        int maxp, dropped;
        maxp = 0; dropped = 0;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            step();
            if (int'(dut2.w_pending) > maxp) maxp = int'(dut2.w_pending);
        end
        checks++; if (ref_ovr2 !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", ref_ovr2); end
        checks++; if (maxp !== 3) begin failures++; $display("FAIL ovr_pending_sat got=%0d exp=3", maxp); end
        for (int k = 0; k < 40; k++) begin
            step();
            if (ref_ovr2 !== 1'b1) dropped = 1;
            if (int'(dut2.w_pending) > maxp) maxp = int'(dut2.w_pending);
        end
        checks++; if (dropped !== 0) begin failures++; $display("FAIL ovr_sticky got=%0d exp=0", dropped); end
        checks++; if (maxp !== 3) begin failures++; $display("FAIL ovr_pending_cap got=%0d exp=3", maxp); end
        checks++; if (ref_ovr !== 1'b0) begin failures++; $display("FAIL ovr_main_clear got=%b exp=0", ref_ovr); end
        nRES = 1'b0;
        step();
        checks++; if (ref_ovr2 !== 1'b0) begin failures++; $display("FAIL ovr_reset_clear got=%b exp=0", ref_ovr2); end
        nRES = 1'b1;
    endtask

    initial begin
        test_reset();
        test_slot_read();
        test_arbitrate();
        test_bg_write();
        test_reset_mid_write();
        test_back_to_back();
        test_ref_vs_bg();
        test_refresh_hold();
        test_ref_ovr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
